// File: rtl/prog_sequencer.sv
// Single-cycle processor sequencer: owns the instruction-memory port, arbitrating
// between the program loader and CPU fetch, and steps the CPU through LOAD/RUN/HALT.
module prog_sequencer #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 16,
  parameter logic [4:0]  HALT_OP = 5'b11111
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_req,
  input  logic               run_req,
  input  logic               stop_req,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [INSTR_W-1:0] ld_data,
  input  logic               ld_last,
  output logic [ADDR_W-1:0]  im_addr,
  output logic [INSTR_W-1:0] im_wdata,
  output logic               im_we,
  input  logic [INSTR_W-1:0] im_rdata,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  pc,
  output logic               cpu_en,
  output logic [1:0]         state,
  output logic [ADDR_W:0]    load_words,
  output logic               load_err,
  output logic [15:0]        instr_count
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10,
    HALT = 2'b11
  } state_t;

  state_t            cur_state;
  state_t            nxt_state;
  logic [ADDR_W-1:0] wr_ptr;
  logic              ld_hs;
  logic              wr_full;
  logic              halt_det;

  assign state    = cur_state;
  assign ld_hs    = (cur_state == LOAD) && ld_valid;
  assign wr_full  = (wr_ptr == '1);
  assign halt_det = (im_rdata[INSTR_W-1 -: 5] == HALT_OP);

  // Address mux kept apart from the cpu_en logic: im_rdata depends on im_addr,
  // so mixing them in one block would form a false combinational loop.
  assign im_addr = (cur_state == LOAD) ? wr_ptr : pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      IDLE, HALT: begin
        if (load_req) begin
          nxt_state = LOAD;
        end else if (run_req) begin
          nxt_state = RUN;
        end
      end
      LOAD: begin
        if (ld_hs && (ld_last || wr_full)) begin
          nxt_state = IDLE;
        end
      end
      RUN: begin
        if (stop_req) begin
          nxt_state = IDLE;
        end else if (halt_det) begin
          nxt_state = HALT;
        end
      end
    endcase
  end

  always_comb begin
    ld_ready = 1'b0;
    im_we    = 1'b0;
    im_wdata = '0;
    cpu_en   = 1'b0;
    case (cur_state)
      LOAD: begin
        ld_ready = 1'b1;
        im_we    = ld_valid;
        im_wdata = ld_data;
      end
      RUN: begin
        cpu_en = !stop_req && !halt_det;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= '0;
      wr_ptr      <= '0;
      load_words  <= '0;
      load_err    <= 1'b0;
      instr_count <= '0;
    end else begin
      case (cur_state)
        IDLE, HALT: begin
          if (load_req) begin
            wr_ptr   <= '0;
            load_err <= 1'b0;
          end else if (run_req) begin
            pc          <= '0;
            instr_count <= '0;
          end
        end
        LOAD: begin
          if (ld_hs) begin
            // Pointer parks at the top address; the load ends there anyway.
            if (!wr_full) begin
              wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (ld_last) begin
              load_words <= {1'b0, wr_ptr} + (ADDR_W + 1)'(1);
            end else if (wr_full) begin
              load_words <= {1'b1, {ADDR_W{1'b0}}};
              load_err   <= 1'b1;
            end
          end
        end
        RUN: begin
          if (!stop_req && !halt_det) begin
            pc <= branch_taken ? branch_target : pc + ADDR_W'(1);
            if (instr_count != '1) begin
              instr_count <= instr_count + 16'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Top-level controller for the single-cycle processor. It owns the single port of the instruction memory and shares it between two users: a program loader, which streams 16-bit words in from outside, and the CPU fetch path, which drives the PC. A four-state FSM sequences the CPU through load, run, halt and stop. It maintains the PC, including branch redirect, gates CPU state updates, detects the HALT opcode and counts retired instructions.

## Interface
Parameters:
- ADDR_W, 8, width of instruction memory address and PC
- INSTR_W, 16, instruction word width
- HALT_OP, 5'b11111, opcode in instr[INSTR_W-1:INSTR_W-5] that halts execution

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- load_req  in  1  request to enter load mode
- run_req  in  1  request to start execution at address 0
- stop_req  in  1  abort execution, return to IDLE
- ld_valid  in  1  loader word valid
- ld_ready  out  1  sequencer accepts loader word
- ld_data  in  INSTR_W  loader word
- ld_last  in  1  marks final word of program
- im_addr  out  ADDR_W  instruction memory address
- im_wdata  out  INSTR_W  instruction memory write data
- im_we  out  1  instruction memory write enable
- im_rdata  in  INSTR_W  instruction at im_addr (combinational read)
- branch_taken  in  1  datapath redirect for current instruction
- branch_target  in  ADDR_W  redirect address
- pc  out  ADDR_W  current PC
- cpu_en  out  1  qualifies CPU register, flag and data-memory writes
- state  out  2  IDLE=00, LOAD=01, RUN=10, HALT=11
- load_words  out  ADDR_W+1  word count of last completed load
- load_err  out  1  sticky flag: memory filled before ld_last
- instr_count  out  16  retired instructions, saturating

## Operation
- IDLE
  - load_req → LOAD, clearing wr_ptr and load_err.
  - Otherwise run_req → RUN, clearing pc and instr_count.
  - load_req has priority.
- LOAD
  - ld_ready=1.
  - On ld_valid&ld_ready, in the same cycle: im_we=1, im_addr=wr_ptr, im_wdata=ld_data. wr_ptr increments on the edge.
  - Handshake with ld_last=1 → IDLE, load_words ← wr_ptr+1.
  - Handshake at wr_ptr=2^ADDR_W−1 without ld_last → IDLE, load_words ← 2^ADDR_W, load_err ← 1. No wrap; address 0 is never overwritten.
  - run_req, stop_req and branch inputs are ignored.
- RUN
  - im_addr=pc, im_we=0, cpu_en=1.
  - Each cycle: pc ← branch_taken ? branch_target : pc+1 (mod 2^ADDR_W; 255+1 wraps to 0). instr_count +1, saturating at 16'hFFFF.
  - If im_rdata opcode == HALT_OP: cpu_en=0 that cycle, pc holds, instr_count does not increment → HALT.
  - stop_req (priority over HALT detect and branch): cpu_en=0 that cycle, pc holds → IDLE.
  - load_req and run_req are ignored.
- HALT
  - cpu_en=0, pc holds and points at the HALT instruction.
  - load_req → LOAD, else run_req → RUN (pc←0, instr_count←0).
- In IDLE and HALT, im_addr=pc and im_we=0.
- ld_ready=0 outside LOAD.

## Timing
- Reset (asynchronous assert, synchronous effect on release edge):
  - state=IDLE, pc=0, wr_ptr=0, load_words=0, load_err=0, instr_count=0.
  - cpu_en=0, ld_ready=0, im_we=0.
- state, pc, wr_ptr, load_words, load_err and instr_count are registered.
- ld_ready, im_we, im_addr, im_wdata and cpu_en are combinational from state and current inputs. There are no registers on the memory path.
- Request latency: a request sampled on edge N takes effect from cycle N+1.
  - The first fetch of address 0 occurs in the first RUN cycle.
  - The first load write occurs in the first LOAD cycle if ld_valid=1.
- Load throughput: one word per cycle. ld_valid may stay high back-to-back.
- Branches: redirect takes effect on the next edge, with zero bubbles.
- Reset mid-LOAD or mid-RUN: immediate return to IDLE. Partial memory contents remain; load_words=0.
- Simultaneous load_req and run_req in IDLE or HALT: LOAD wins.

## Test plan
- Reset, then load_req and stream 4 words (last on word 3) back-to-back → im_we high for 4 cycles at addresses 0..3, state=IDLE, load_words=4, load_err=0.
- Load 256 words with ld_last never asserted → writes at addresses 0..255, state=IDLE after word 255, load_words=256, load_err=1.
- Load 3 NOPs followed by a HALT word, then run_req → pc sequence 0,1,2,3; HALT reached with pc=3, cpu_en=0, instr_count=3.
- In RUN, assert branch_taken with target 8'h10 at pc=1 → next pc=8'h10. Separately, reach pc=8'hFF without branch → next pc=0.
- stop_req asserted in the same cycle as a HALT opcode and branch_taken → state=IDLE, pc unchanged, cpu_en=0.
- Assert rst_n=0 mid-load after 2 words → all outputs return to reset values immediately, and a new load_req is accepted on the following cycle.
